sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//  Parametrised single-clock FIFO, next generation of the team's basic FIFO.
//  Pointers carry a wrap bit, so all DEPTH entries are usable and FULL/EMPTY are exact.
//  Adds an occupancy count, programmable almost-full/almost-empty flags,
//  one-cycle overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
//  Sits between producer/consumer blocks (UART, SPI and similar streams) in the same clock domain.
// PARAMETERS
//  DATA_LEN     8           data word width in bits (>=1)
//  DEPTH        16          number of entries; power of two, >=2
//  AF_THR       DEPTH-2     ALMOST_FULL_OW asserts when count >= AF_THR (1..DEPTH)
//  AE_THR       2           ALMOST_EMPTY_OW asserts when count <= AE_THR (0..DEPTH-1)
//  FWFT         0           0 = registered read, 1 = first-word-fall-through
// PORTS
//  CLK_IW          in   1              clock, rising edge
//  RST_N_IW        in   1              synchronous reset, active-low
//  DATA_IN_I       in   DATA_LEN       write data
//  WRITE_EN_IW     in   1              write request
//  READ_EN_IW      in   1              read request (pop)
//  DATA_OUT_OR     out  DATA_LEN       read data
//  VALID_OR        out  1              DATA_OUT_OR holds a valid word
//  FULL_OW         out  1              count == DEPTH
//  EMPTY_OW        out  1              count == 0
//  ALMOST_FULL_OW  out  1              count >= AF_THR
//  ALMOST_EMPTY_OW out  1              count <= AE_THR
//  COUNT_OR        out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  OVERFLOW_OR     out  1              1-cycle pulse: write request rejected
//  UNDERFLOW_OR    out  1              1-cycle pulse: read request rejected
// BEHAVIOUR
//  - Reset (RST_N_IW=0 at a clock edge):
//    - wr/rd pointers and COUNT_OR go to 0; DATA_OUT_OR, VALID_OR, OVERFLOW_OR and UNDERFLOW_OR go to 0.
//    - Consequently EMPTY_OW=1, FULL_OW=0, ALMOST_EMPTY_OW=1, ALMOST_FULL_OW=(AF_THR==0).
//    - Memory array is not cleared.
//    - Reset mid-operation discards all stored words; requests in the reset cycle are ignored and raise no error pulses.
//  - Pointers are $clog2(DEPTH)+1 bits; the low bits address memory, the MSB is the wrap bit.
//    They increment modulo 2*DEPTH.
//  - Write accepted iff WRITE_EN_IW && !FULL_OW.
//    - Accepted: mem[wr] <= DATA_IN_I and wr increments.
//    - Rejected: OVERFLOW_OR=1 the next cycle; no state change.
//  - Read accepted iff READ_EN_IW && !EMPTY_OW.
//    - Accepted: rd increments.
//    - Rejected: UNDERFLOW_OR=1 the next cycle.
//  - Flags are evaluated on pre-edge state. So:
//    - Write on full is rejected even with a simultaneous read.
//    - Read on empty is rejected even with a simultaneous write.
//  - COUNT_OR next value = count + wr_acc - rd_acc. Simultaneous accepted read and write leaves the count unchanged.
//  - FULL_OW, EMPTY_OW, ALMOST_FULL_OW and ALMOST_EMPTY_OW are combinational from COUNT_OR.
//    They update the cycle after the accepting edge.
//  - FWFT=0 (registered read):
//    - On an accepted read, DATA_OUT_OR <= mem[rd] and VALID_OR <= 1.
//    - Otherwise VALID_OR <= 0 and DATA_OUT_OR holds its value.
//    - Read latency is 1 cycle.
//  - FWFT=1 (fall-through):
//    - DATA_OUT_OR = EMPTY_OW ? 0 : mem[rd] and VALID_OR = !EMPTY_OW.
//    - A written word becomes visible 1 cycle after its write edge.
//    - READ_EN_IW acknowledges (pops) the presented word.
//  - Reading an address in the same cycle it is written is impossible: the count would have to be 0 or DEPTH, so no bypass is needed.
//  - Illegal parameters (DEPTH not a power of two, DEPTH<2, AF_THR or AE_THR out of range) raise an elaboration $error.
// TESTING
//  1. Reset, then 16 writes 0x00..0x0F (DEPTH=16):
//     -> COUNT_OR=16, FULL_OW=1; ALMOST_FULL_OW rises when count reaches 14.
//     -> A 17th write gives OVERFLOW_OR=1 for 1 cycle, COUNT_OR stays 16.
//  2. From full, 16 reads (FWFT=0):
//     -> DATA_OUT_OR=0x00..0x0F, each 1 cycle after its READ_EN_IW, with VALID_OR=1.
//     -> EMPTY_OW=1 afterwards; a 17th read gives UNDERFLOW_OR=1 and VALID_OR=0.
//  3. Wrap-around: 40 write/read pairs with count held at 5, both enables high each cycle:
//     -> COUNT_OR stays 5 throughout.
//     -> Output sequence is the exact input sequence across both pointer wraps.
//  4. Simultaneous events:
//     -> Full + write + read: read accepted, write rejected, OVERFLOW_OR=1, COUNT_OR=15.
//     -> Empty + write + read: write accepted, UNDERFLOW_OR=1, COUNT_OR=1.
//  5. FWFT=1: write 0xA5 into an empty FIFO:
//     -> Next cycle VALID_OR=1 and DATA_OUT_OR=0xA5 with no read.
//     -> Read: next cycle VALID_OR=0 and DATA_OUT_OR=0.
//  6. Write 9 words, then RST_N_IW=0 for 1 cycle with WRITE_EN_IW=1:
//     -> COUNT_OR=0, EMPTY_OW=1, no error pulses.
//     -> The next write/read returns the new word.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count, programmable
// almost-full/almost-empty flags, overflow/underflow pulses and optional FWFT read.
module sync_fifo_flags #(
  parameter int DATA_LEN = 8,
  parameter int DEPTH    = 16,
  parameter int AF_THR   = DEPTH - 2,
  parameter int AE_THR   = 2,
  parameter int FWFT     = 0
) (
  input  logic                       CLK_IW,
  input  logic                       RST_N_IW,
  input  logic [DATA_LEN-1:0]        DATA_IN_I,
  input  logic                       WRITE_EN_IW,
  input  logic                       READ_EN_IW,
  output logic [DATA_LEN-1:0]        DATA_OUT_OR,
  output logic                       VALID_OR,
  output logic                       FULL_OW,
  output logic                       EMPTY_OW,
  output logic                       ALMOST_FULL_OW,
  output logic                       ALMOST_EMPTY_OW,
  output logic [$clog2(DEPTH):0]     COUNT_OR,
  output logic                       OVERFLOW_OR,
  output logic                       UNDERFLOW_OR
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
    end
    if (AF_THR < 1 || AF_THR > DEPTH) begin : g_bad_af
      $error("sync_fifo_flags: AF_THR must be in 1..DEPTH");
    end
    if (AE_THR < 0 || AE_THR > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_flags: AE_THR must be in 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [AW-1:0]       wr_addr, rd_addr;
  logic                wr_acc, rd_acc;

  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  // Acceptance uses pre-edge flags: a read never frees room for a same-cycle write.
  assign wr_acc = WRITE_EN_IW && !FULL_OW;
  assign rd_acc = READ_EN_IW  && !EMPTY_OW;

  assign FULL_OW         = (COUNT_OR == PW'(DEPTH));
  assign EMPTY_OW        = (COUNT_OR == '0);
  assign ALMOST_FULL_OW  = (COUNT_OR >= PW'(AF_THR));
  assign ALMOST_EMPTY_OW = (COUNT_OR <= PW'(AE_THR));

  always_ff @(posedge CLK_IW) begin
    if (!RST_N_IW) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      COUNT_OR     <= '0;
      OVERFLOW_OR  <= 1'b0;
      UNDERFLOW_OR <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      COUNT_OR     <= COUNT_OR + PW'(wr_acc) - PW'(rd_acc);
      OVERFLOW_OR  <= WRITE_EN_IW && !wr_acc;
      UNDERFLOW_OR <= READ_EN_IW  && !rd_acc;
    end
  end

  // Storage is not reset; a write arriving during reset is dropped.
  always_ff @(posedge CLK_IW) begin
    if (RST_N_IW && wr_acc) mem[wr_addr] <= DATA_IN_I;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign VALID_OR    = !EMPTY_OW;
      assign DATA_OUT_OR = EMPTY_OW ? '0 : mem[rd_addr];
    end else begin : g_reg
      logic [DATA_LEN-1:0] dout_q;
      logic                vld_q;
      always_ff @(posedge CLK_IW) begin
        if (!RST_N_IW) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_addr];
        end
      end
      assign VALID_OR    = vld_q;
      assign DATA_OUT_OR = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: registered and FWFT instances share stimulus and
// are checked every cycle against a queue-based model of the FIFO rules.
module tb_sync_fifo_flags;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] din = '0;
  logic          we = 1'b0, re = 1'b0;

  logic [DW-1:0] r_dout, f_dout;
  logic          r_vld, r_full, r_empty, r_af, r_ae, r_ov, r_un;
  logic          f_vld, f_full, f_empty, f_af, f_ae, f_ov, f_un;
  logic [CW-1:0] r_cnt, f_cnt;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_vld = 1'b0, m_ov = 1'b0, m_un = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_LEN(DW), .DEPTH(DEPTH), .AF_THR(AF), .AE_THR(AE), .FWFT(0)) u_reg (
    .CLK_IW(clk), .RST_N_IW(rst_n), .DATA_IN_I(din), .WRITE_EN_IW(we), .READ_EN_IW(re),
    .DATA_OUT_OR(r_dout), .VALID_OR(r_vld), .FULL_OW(r_full), .EMPTY_OW(r_empty),
    .ALMOST_FULL_OW(r_af), .ALMOST_EMPTY_OW(r_ae), .COUNT_OR(r_cnt),
    .OVERFLOW_OR(r_ov), .UNDERFLOW_OR(r_un));

  sync_fifo_flags #(.DATA_LEN(DW), .DEPTH(DEPTH), .AF_THR(AF), .AE_THR(AE), .FWFT(1)) u_ft (
    .CLK_IW(clk), .RST_N_IW(rst_n), .DATA_IN_I(din), .WRITE_EN_IW(we), .READ_EN_IW(re),
    .DATA_OUT_OR(f_dout), .VALID_OR(f_vld), .FULL_OW(f_full), .EMPTY_OW(f_empty),
    .ALMOST_FULL_OW(f_af), .ALMOST_EMPTY_OW(f_ae), .COUNT_OR(f_cnt),
    .OVERFLOW_OR(f_ov), .UNDERFLOW_OR(f_un));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count",   32'(r_cnt),   32'(n));
    chk("full",    32'(r_full),  32'(n == DEPTH));
    chk("empty",   32'(r_empty), 32'(n == 0));
    chk("afull",   32'(r_af),    32'(n >= AF));
    chk("aempty",  32'(r_ae),    32'(n <= AE));
    chk("ovf",     32'(r_ov),    32'(m_ov));
    chk("unf",     32'(r_un),    32'(m_un));
    chk("dout",    32'(r_dout),  32'(m_dout));
    chk("valid",   32'(r_vld),   32'(m_vld));
    chk("ft_count", 32'(f_cnt),  32'(n));
    chk("ft_ovf",  32'(f_ov),    32'(m_ov));
    chk("ft_unf",  32'(f_un),    32'(m_un));
    chk("ft_valid", 32'(f_vld),  32'(n != 0));
    chk("ft_dout", 32'(f_dout),  (n != 0) ? 32'(q[0]) : 32'd0);
  endtask

  // One clock: drive at negedge, advance the model at the edge, check 1 time unit later.
  task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    int  n;
    logic wacc, racc;
    @(negedge clk);
    rst_n = r; we = w; re = rd; din = d;
    @(posedge clk);
    n    = q.size();
    wacc = w  && (n < DEPTH);
    racc = rd && (n > 0);
    if (!r) begin
      q.delete();
      m_dout = '0; m_vld = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      m_vld = racc;
      if (racc) m_dout = q.pop_front();
      if (wacc) q.push_back(d);
      m_ov = w  && !wacc;
      m_un = rd && !racc;
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    // 16 writes 0x00..0x0F, then an overflowing 17th
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, DW'(i));
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    step(1'b1, 1'b0, 1'b0, '0);
    // 16 reads, then an underflowing 17th
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    // Wrap-around with count held at 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1, DW'($urandom));
    // Fill to full, then write+read on full
    while (q.size() < DEPTH) step(1'b1, 1'b1, 1'b0, DW'($urandom));
    step(1'b1, 1'b1, 1'b1, 8'h77);
    // Drain to empty, then write+read on empty
    while (q.size() > 0) step(1'b1, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b1, 8'h3C);
    step(1'b1, 1'b0, 1'b1, '0);
    // FWFT presentation of a single word
    step(1'b1, 1'b1, 1'b0, 8'hA5);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    // Reset mid-operation with a write request present
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, DW'(8'h50 + i));
    step(1'b0, 1'b1, 1'b0, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 8'h9D);
    step(1'b1, 1'b0, 1'b1, '0);
    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) != 0), 1'($urandom), 1'($urandom), DW'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
